compare_batch_controller: RTL
=============================

// Module: compare_batch_controller
// PURPOSE
// - Multi-cycle custom-instruction unit that sequences the 2-bit pixel comparison over a batch of words.
// - CPU loads two word buffers (A, B) through CI ops, issues RUN, and reads back per-word results and a mismatch count.
// - Replaces one-CI-per-word comparison in the movement-detection loop; sits on the CPU custom-instruction bus.
// PARAMETERS
// - customInstructionId  8'd0  CI number this unit responds to.
// - ADDR_W               6     Buffer index width; DEPTH = 2**ADDR_W words per buffer (A, B, R).
// PORTS
// - clock    in   1   system clock; all logic rising-edge.
// - reset    in   1   synchronous, active-low reset.
// - start    in   1   CI start strobe.
// - valueA   in   32  [3:0] op, [4] early-exit request, [ADDR_W+7:8] buffer index.
// - valueB   in   32  write data (WRITE_A/B) or word count (RUN, [ADDR_W:0]).
// - ciN      in   8   CI number; accepted only when equal to customInstructionId.
// - done     out  1   one-cycle completion pulse.
// - result   out  32  op result; 32'b0 whenever done=0.
// BEHAVIOUR
// - Accept: start=1, ciN==customInstructionId, FSM in IDLE. Any other start is ignored: no done, no state change.
// - Word compare: msb = (A[1]==B[1]) ? {16{A[1]}} : 16'h6000; lsb is the same on bit 0. R = {msb,lsb}.
// - Mismatch count: +1 per differing bit (0..2 per word); 16-bit register, saturates at 16'hFFFF.
// - Ops (valueA[3:0]); single-cycle ops finish with done at accept+1:
//   0 WRITE_A: A[idx] <= valueB; result 0.  1 WRITE_B: B[idx] <= valueB; result 0.
//   3 READ_R: sync read of R[idx]; result = R[idx].  4 STATUS: result = {16'b0, last mismatch count}.
//   2 RUN: n = valueB[ADDR_W:0]; n > DEPTH is clamped to DEPTH.
//   Other op codes: done at accept+1, result 0.
// - RUN FSM: IDLE -> FETCH -> COMPARE -> (FETCH | DONE) -> IDLE.
//   - On accept: index i=0, count cleared.
//   - FETCH: issue A[i], B[i] read address.
//   - COMPARE: write R[i], add mismatches, i++; go to DONE after word n-1.
//   - DONE: done=1, result = {16'b0, count}; count retained for STATUS.
//   - Latency: done exactly 2n+1 cycles after the accept cycle. n=0: done at accept+1, result 0.
//   - No new start is accepted before the return to IDLE, i.e. the cycle after done.
// - Buffers: three DEPTH x 32 sync-read RAMs, 1-cycle read latency. A/B are written only by the CPU; R only by RUN.
// - Indices wrap modulo DEPTH (upper valueA bits ignored).
// - Reset (reset=0 at a clock edge):
//   - FSM -> IDLE; done=0; result=0; i=0; count=0.
//   - A/B/R contents are not cleared.
//   - Reset mid-RUN aborts the run with no done pulse; R keeps the words already written.
// CONFIGURATION
// - Macro CMP_CTRL_EARLY_EXIT_EN:
//   - Defined: RUN with valueA[4]=1 ends after the first word with mismatch>0 (that word's R is written).
//     Then result = {1'b1, idx[14:0], count[15:0]}, done at accept+2(k+1)+1 for stop word k.
//     If no mismatch occurs, the run is identical to a normal RUN with result[31]=0.
//     RUN with valueA[4]=0 behaves as a normal RUN.
//   - Undefined: valueA[4] is ignored; every RUN processes all n words; result[31:16]=0.
// TESTING
// - Load A[0]=3, B[0]=3, A[1]=1, B[1]=2; RUN n=2 -> done at accept+5, result=2; READ_R 0 -> 32'hFFFFFFFF; READ_R 1 -> 32'h60006000.
// - start=1, ciN=id+1, WRITE_A idx 0 = 5 -> done stays 0, result 0, later READ_A-derived RUN shows A[0] unchanged.
// - RUN n=0 -> done at accept+1, result 0. RUN n=100 (ADDR_W=6) -> clamped to 64, done at accept+129.
// - start during RUN ignored (no extra done). reset=0 at FETCH of word 3 -> done 0, result 0 next cycle;
//   new RUN n=1 completes at accept+3.
// - EARLY_EXIT_EN, A[0..3]=0, B[2]=1, RUN n=4, valueA[4]=1 -> done at accept+7, result=32'h80020001; STATUS -> 1.
// - 70000 mismatching words over repeated RUNs within one run limit: DEPTH=64 all-mismatch (A=0, B=3) -> result=128;
//   STATUS -> 128.

Source files
------------

// File: rtl/compare_batch_controller_if.sv
// CPU custom-instruction bus for compare_batch_controller: CPU drives start/operands, unit returns done/result.
// Latency and backpressure are properties of the unit; this bundle carries no flow control beyond done.
interface compare_batch_controller_if;
  logic        start;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [7:0]  ciN;
  logic        done;
  logic [31:0] result;

  modport master (output start, output valueA, output valueB, output ciN,
                  input  done,  input  result);
  modport slave  (input  start, input  valueA, input  valueB, input  ciN,
                  output done,  output result);
endinterface

// File: rtl/compare_batch_controller.sv
// Batch 2-bit pixel compare CI unit; macro CMP_CTRL_EARLY_EXIT_EN adds stop-on-first-mismatch RUN.
// Latency: single-cycle ops done at accept+1; RUN done at accept+2n+1.
// Backpressure: none; starts outside IDLE or for another CI number are silently dropped.
module compare_batch_controller #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int         ADDR_W              = 6
) (
  input logic                clock,
  input logic                reset,
  compare_batch_controller_if.slave ci
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [3:0] OP_WRITE_A = 4'd0;
  localparam logic [3:0] OP_WRITE_B = 4'd1;
  localparam logic [3:0] OP_RUN     = 4'd2;
  localparam logic [3:0] OP_READ_R  = 4'd3;
  localparam logic [3:0] OP_STATUS  = 4'd4;

  typedef enum logic [1:0] {IDLE, FETCH, COMPARE, DONE} state_t;

  state_t state, state_d;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] mem_r [DEPTH];

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] i_q, last_q;
  logic [15:0]       count_q;
  logic [31:0]       a_rd, b_rd, r_rd;

  logic              accept;
  logic [3:0]        op_in;
  logic [ADDR_W-1:0] idx_in;
  logic [ADDR_W:0]   n_clamp, n_m1;
  logic [1:0]        mism;
  logic [31:0]       r_word;
  logic [16:0]       count_sum;
  logic [15:0]       count_next;
  logic              early_stop;
  logic [31:0]       run_res;
  logic [31:0]       res;
  logic              unused_bits;

  // Reset has priority over an accept presented on the same edge.
  assign accept = reset && ci.start && (ci.ciN == customInstructionId) && (state == IDLE);
  assign op_in  = ci.valueA[3:0];
  assign idx_in = ci.valueA[ADDR_W+7:8];

  always_comb begin
    n_clamp = ci.valueB[ADDR_W:0];
    if (ci.valueB[ADDR_W:0] > DEPTH_N) n_clamp = DEPTH_N;
    n_m1 = n_clamp - {{ADDR_W{1'b0}}, 1'b1};
  end

  // Only bit 1 and bit 0 of each word carry the pixel; the rest of the word is don't-care.
  always_comb begin
    mism       = {1'b0, a_rd[1] ^ b_rd[1]} + {1'b0, a_rd[0] ^ b_rd[0]};
    r_word     = {(a_rd[1] == b_rd[1]) ? {16{a_rd[1]}} : 16'h6000,
                  (a_rd[0] == b_rd[0]) ? {16{a_rd[0]}} : 16'h6000};
    count_sum  = {1'b0, count_q} + {15'b0, mism};
    count_next = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

`ifdef CMP_CTRL_EARLY_EXIT_EN
  logic        ee_q, hit_q;
  logic [14:0] stop_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ee_q   <= 1'b0;
      hit_q  <= 1'b0;
      stop_q <= 15'd0;
    end else if (accept && op_in == OP_RUN) begin
      ee_q   <= ci.valueA[4];
      hit_q  <= 1'b0;
      stop_q <= 15'd0;
    end else if (early_stop) begin
      hit_q  <= 1'b1;
      stop_q <= 15'(i_q);
    end
  end

  assign early_stop  = ee_q && (state == COMPARE) && (mism != 2'd0);
  assign run_res     = {hit_q, stop_q, count_q};
  assign unused_bits = ^{ci.valueA[31:ADDR_W+8], ci.valueA[7:5], ci.valueB[31:ADDR_W+1]};
`else
  assign early_stop  = 1'b0;
  assign run_res     = {16'b0, count_q};
  assign unused_bits = ^{ci.valueA[31:ADDR_W+8], ci.valueA[7:4], ci.valueB[31:ADDR_W+1]};
`endif

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept) state_d = (op_in == OP_RUN && n_clamp != '0) ? FETCH : DONE;
      FETCH:   state_d = COMPARE;
      COMPARE: state_d = (i_q == last_q || early_stop) ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q    <= 4'd0;
      i_q     <= '0;
      last_q  <= '0;
      count_q <= 16'd0;
    end else begin
      if (accept) begin
        op_q <= op_in;
        if (op_in == OP_RUN) begin
          i_q     <= '0;
          last_q  <= n_m1[ADDR_W-1:0];
          count_q <= 16'd0;
        end
      end
      if (state == COMPARE) begin
        count_q <= count_next;
        i_q     <= i_q + 1'b1;
      end
    end
  end

  // Buffer contents survive reset; writes are gated so an aborting reset edge leaves R untouched.
  always_ff @(posedge clock) begin
    if (accept && op_in == OP_WRITE_A) mem_a[idx_in] <= ci.valueB;
    if (accept && op_in == OP_WRITE_B) mem_b[idx_in] <= ci.valueB;
    if (accept && op_in == OP_READ_R)  r_rd <= mem_r[idx_in];
    if (state == FETCH) begin
      a_rd <= mem_a[i_q];
      b_rd <= mem_b[i_q];
    end
    if (reset && state == COMPARE) mem_r[i_q] <= r_word;
  end

  always_comb begin
    res = 32'd0;
    if (state == DONE) begin
      case (op_q)
        OP_READ_R: res = r_rd;
        OP_STATUS: res = {16'b0, count_q};
        OP_RUN:    res = run_res;
        default:   res = 32'd0;
      endcase
    end
  end

  assign ci.done   = (state == DONE);
  assign ci.result = res;

endmodule
